// File: rtl/bubble_sort_swapper_if.sv
// Write/read/control bundle for bubble_sort_swapper. The master side loads data and
// starts sorts; the slave side is the sorting register file.
interface bubble_sort_swapper_if #(
    parameter int N    = 3,
    parameter int BITS = 8
);
    logic            w_en;
    logic [N-1:0]    w_addr;
    logic [BITS-1:0] w_data;
    logic [N-1:0]    r_addr;
    logic [BITS-1:0] r_data;
    logic            start;
    logic            busy;
    logic            done;
    logic [2*N-1:0]  swap_cnt;

    modport master (
        output w_en, w_addr, w_data, r_addr, start,
        input  r_data, busy, done, swap_cnt
    );

    modport slave (
        input  w_en, w_addr, w_data, r_addr, start,
        output r_data, busy, done, swap_cnt
    );
endinterface

// File: rtl/bubble_sort_swapper.sv
// Register file with one write and one combinational read port, plus a controller
// that bubble-sorts the contents in place (ascending, unsigned) using pairwise swaps.
module bubble_sort_swapper #(
    parameter int N    = 3,
    parameter int BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    bubble_sort_swapper_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** N;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_SWAP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [BITS-1:0] mem [DEPTH];
    logic [1:0]      state;
    logic [N-1:0]    i;
    logic [N-1:0]    p;
    logic            pass_swapped;
    logic [2*N-1:0]  swap_cnt;

    logic [N-1:0]    i_nxt;
    logic [N-1:0]    lim;
    logic            out_of_order;
    logic            last_pair;
    logic            swapped_eff;
    logic            finish;

    assign i_nxt        = i + N'(1);
    assign lim          = N'(DEPTH - 2) - p;
    assign out_of_order = mem[i] > mem[i_nxt];
    assign last_pair    = (i >= lim);
    // A swap issued in this very cycle must count toward the pass, or a pass whose
    // only swap is on its last pair would wrongly end the sort.
    assign swapped_eff  = pass_swapped | (state == S_SWAP);
    assign finish       = !swapped_eff || (p == N'(DEPTH - 2));

    assign bus.r_data   = mem[bus.r_addr];
    assign bus.busy     = (state == S_CMP) || (state == S_SWAP);
    assign bus.done     = (state == S_DONE);
    assign bus.swap_cnt = swap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            state        <= S_IDLE;
            i            <= '0;
            p            <= '0;
            pass_swapped <= 1'b0;
            swap_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.w_en) begin
                        mem[bus.w_addr] <= bus.w_data;
                    end
                    if (bus.start) begin
                        p            <= '0;
                        i            <= '0;
                        swap_cnt     <= '0;
                        pass_swapped <= 1'b0;
                        state        <= S_CMP;
                    end
                end

                S_CMP, S_SWAP: begin
                    if (state == S_CMP && out_of_order) begin
                        state <= S_SWAP;
                    end else begin
                        if (state == S_SWAP) begin
                            mem[i]       <= mem[i_nxt];
                            mem[i_nxt]   <= mem[i];
                            swap_cnt     <= swap_cnt + (2*N)'(1);
                            pass_swapped <= 1'b1;
                        end
                        state <= S_CMP;
                        if (!last_pair) begin
                            i <= i_nxt;
                        end else if (finish) begin
                            state <= S_DONE;
                        end else begin
                            p            <= p + N'(1);
                            i            <= '0;
                            pass_swapped <= 1'b0;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bubble_sort_swapper.sv
// Directed bench for bubble_sort_swapper: expected sorted contents, swap counts and busy
// lengths are queued at start and popped when done pulses.
module tb_bubble_sort_swapper;
    logic clk = 1'b0;
    logic rst = 1'b1;

    bubble_sort_swapper_if #(.N(3), .BITS(8)) bif ();

    bubble_sort_swapper #(.N(3), .BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][7:0] v;
        int              swaps;
        int              busy;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  tb_mem [8];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bif.w_en   = 1'b1;
        bif.w_addr = a;
        bif.w_data = d;
        tb_mem[a]  = d;
        @(negedge clk);
        bif.w_en   = 1'b0;
    endtask

    // Expected result: insertion sort for order, inversion count for swaps.
    function automatic exp_t model(input int exp_busy);
        exp_t       e;
        logic [7:0] a [8];
        logic [7:0] t;
        int         j;
        e.swaps = 0;
        for (int x = 0; x < 8; x++) a[x] = tb_mem[x];
        for (int x = 0; x < 8; x++)
            for (int y = x + 1; y < 8; y++)
                if (a[x] > a[y]) e.swaps++;
        for (int x = 1; x < 8; x++) begin
            t = a[x];
            j = x - 1;
            while (j >= 0 && a[j] > t) begin
                a[j+1] = a[j];
                j--;
            end
            a[j+1] = t;
        end
        for (int x = 0; x < 8; x++) e.v[x] = a[x];
        e.busy = exp_busy;
        return e;
    endfunction

    task automatic check_mem(input string name, input logic [7:0][7:0] v);
        for (int a = 0; a < 8; a++) begin
            bif.r_addr = 3'(a);
            #1;
            check($sformatf("%s_mem%0d", name, a), {24'h0, bif.r_data}, {24'h0, v[a]});
        end
    endtask

    task automatic run_sort(input string name, input int exp_busy, input bit disturb,
                            input bit wr_with_start, input logic [2:0] wa, input logic [7:0] wd);
        exp_t e;
        int   busy_n;
        bit   got_done;
        @(negedge clk);
        bif.start = 1'b1;
        if (wr_with_start) begin
            bif.w_en   = 1'b1;
            bif.w_addr = wa;
            bif.w_data = wd;
            tb_mem[wa] = wd;
        end
        sb.push_back(model(exp_busy));
        @(negedge clk);
        bif.start = 1'b0;
        bif.w_en  = 1'b0;
        busy_n    = 0;
        got_done  = 1'b0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            if (bif.busy) busy_n++;
            if (bif.done) got_done = 1'b1;
            if (disturb && c == 3) begin
                bif.w_en   = 1'b1;
                bif.w_addr = 3'd0;
                bif.w_data = 8'hFF;
                bif.start  = 1'b1;
            end else if (disturb && c == 4) begin
                bif.w_en  = 1'b0;
                bif.start = 1'b0;
            end
            if (!got_done) @(negedge clk);
        end
        check({name, "_done_seen"}, {31'h0, got_done}, 32'd1);
        e = sb.pop_front();
        check({name, "_busy_cycles"}, busy_n, e.busy);
        check({name, "_swap_cnt"}, {26'h0, bif.swap_cnt}, e.swaps);
        check_mem(name, e.v);
        for (int x = 0; x < 8; x++) tb_mem[x] = e.v[x];
        @(negedge clk);
        check({name, "_done_width"}, {31'h0, bif.done}, 32'd0);
        check({name, "_busy_after"}, {31'h0, bif.busy}, 32'd0);
    endtask

    initial begin
        int done_n;
        bif.w_en   = 1'b0;
        bif.w_addr = '0;
        bif.w_data = '0;
        bif.r_addr = '0;
        bif.start  = 1'b0;
        for (int x = 0; x < 8; x++) tb_mem[x] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", {31'h0, bif.busy}, 32'd0);
        check("rst_done", {31'h0, bif.done}, 32'd0);
        check("rst_swap_cnt", {26'h0, bif.swap_cnt}, 32'd0);
        check_mem("rst", '0);

        // Reverse order: worst case.
        for (int a = 0; a < 8; a++) write(3'(a), 8'(7 - a));
        run_sort("rev", 56, 1'b0, 1'b0, 3'd0, 8'd0);

        // Already sorted: single pass, early exit.
        for (int a = 0; a < 8; a++) write(3'(a), 8'(a));
        run_sort("sorted", 7, 1'b0, 1'b0, 3'd0, 8'd0);

        // Equal values never swapped.
        for (int a = 0; a < 8; a++) write(3'(a), (a == 3) ? 8'h00 : 8'hA5);
        run_sort("equal", 25, 1'b0, 1'b0, 3'd0, 8'd0);

        // Write and start while busy are ignored.
        for (int a = 0; a < 8; a++) write(3'(a), (a == 3) ? 8'h00 : 8'hA5);
        run_sort("ignore", 25, 1'b1, 1'b0, 3'd0, 8'd0);
        repeat (3) begin
            @(negedge clk);
            check("ignore_no_restart", {31'h0, bif.busy}, 32'd0);
        end
        check("ignore_swap_hold", {26'h0, bif.swap_cnt}, 32'd3);

        // Reset mid-sort.
        for (int a = 0; a < 8; a++) write(3'(a), 8'(7 - a));
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {31'h0, bif.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'h0, bif.busy}, 32'd0);
        check("abort_swap_cnt", {26'h0, bif.swap_cnt}, 32'd0);
        for (int x = 0; x < 8; x++) tb_mem[x] = 8'h00;
        check_mem("abort", '0);
        done_n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bif.done || bif.busy) done_n++;
        end
        check("abort_no_done", done_n, 32'd0);

        // Write coinciding with start is included in the sort.
        for (int a = 0; a < 8; a++) write(3'(a), 8'(a + 1));
        run_sort("wr_start", 35, 1'b0, 1'b1, 3'd7, 8'h00);

        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
